// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory byte unit: access-type encodings
// and the store-trace record layout.
package dm_pkg;

  localparam logic [1:0] OP_WORD  = 2'b00;
  localparam logic [1:0] OP_BYTE  = 2'b01;
  localparam logic [1:0] OP_BYTEU = 2'b10;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] data;
  } trace_rec_t;

  // The reserved encoding 2'b11 behaves as a word access.
  function automatic logic is_word_op(input logic [1:0] op);
    return !((op == OP_BYTE) || (op == OP_BYTEU));
  endfunction

endpackage

// File: rtl/dm_lane_mux.sv
// Little-endian byte-lane helper: extracts one lane for loads (sign or zero
// extended) and merges one byte into a word for stores.
module dm_lane_mux (
  input  logic [31:0] i_word,
  input  logic [1:0]  i_lane,
  input  logic        i_sign,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_load,
  output logic [31:0] o_merged
);

  logic [7:0] w_lane;

  always_comb begin
    w_lane   = i_word[7:0];
    o_merged = i_word;
    case (i_lane)
      2'd0: begin
        w_lane         = i_word[7:0];
        o_merged[7:0]  = i_byte;
      end
      2'd1: begin
        w_lane         = i_word[15:8];
        o_merged[15:8] = i_byte;
      end
      2'd2: begin
        w_lane          = i_word[23:16];
        o_merged[23:16] = i_byte;
      end
      default: begin
        w_lane          = i_word[31:24];
        o_merged[31:24] = i_byte;
      end
    endcase
  end

  assign o_load = i_sign ? {{24{w_lane[7]}}, w_lane} : {24'h000000, w_lane};

endmodule

// File: rtl/dm_byte_unit.sv
// Data memory for the single-cycle core: combinational word/byte loads,
// single-cycle word/byte stores, access fault flags and a registered store trace.
module dm_byte_unit
  import dm_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  input  logic [1:0]  op,
  output logic [31:0] rdata,
  output logic        misalign,
  output logic        oor,
  output logic        trace_valid,
  output logic [31:0] trace_pc,
  output logic [31:0] trace_addr,
  output logic [31:0] trace_data,
  output logic [31:0] store_cnt
);

  localparam logic [31:0] ADDR_LIMIT = 32'(4 * DEPTH);

  logic [31:0] r_mem [DEPTH];
  trace_rec_t  r_trace;
  logic        r_valid;
  logic [31:0] r_cnt;

  logic [IDX_W-1:0] w_idx;
  logic             w_word_op;
  logic             w_misalign;
  logic             w_oor;
  logic             w_accept;
  logic [31:0]      w_cur;
  logic [31:0]      w_lane_load;
  logic [31:0]      w_lane_merged;
  logic [31:0]      w_store_word;

  assign w_idx      = addr[IDX_W+1:2];
  assign w_word_op  = is_word_op(op);
  assign w_misalign = w_word_op && (addr[1:0] != 2'b00);
  assign w_oor      = (addr >= ADDR_LIMIT);
  assign w_cur      = r_mem[w_idx];

  // One lane mux serves both directions: the load extract and the store merge
  // both operate on the currently addressed word.
  dm_lane_mux u_lane_mux (
    .i_word   (w_cur),
    .i_lane   (addr[1:0]),
    .i_sign   (op == OP_BYTE),
    .i_byte   (wdata[7:0]),
    .o_load   (w_lane_load),
    .o_merged (w_lane_merged)
  );

  always_comb begin
    rdata = 32'h0000_0000;
    if (!w_oor) begin
      if (w_word_op) begin
        if (!w_misalign) rdata = w_cur;
      end else begin
        rdata = w_lane_load;
      end
    end
  end

  assign w_accept     = reset && we && !w_oor && !w_misalign;
  assign w_store_word = w_word_op ? wdata : w_lane_merged;

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= 32'h0000_0000;
      r_trace <= '0;
      r_valid <= 1'b0;
      r_cnt   <= 32'h0000_0000;
    end else begin
      r_valid <= w_accept;
      if (w_accept) begin
        r_mem[w_idx]  <= w_store_word;
        r_trace.pc    <= pc;
        r_trace.addr  <= {addr[31:2], 2'b00};
        r_trace.data  <= w_store_word;
        r_cnt         <= r_cnt + 32'd1;
      end
    end
  end

  assign misalign    = w_misalign;
  assign oor         = w_oor;
  assign trace_valid = r_valid;
  assign trace_pc    = r_trace.pc;
  assign trace_addr  = r_trace.addr;
  assign trace_data  = r_trace.data;
  assign store_cnt   = r_cnt;

endmodule
